// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one byte-wide RAM port between instruction fetch (IF) and the
//   load/store stage (MEM). Every 1/2/4-byte access is broken into byte
//   cycles. Read bytes are assembled into a little-endian word and write
//   words are split into bytes. A MEM request wins over an IF request in
//   IDLE. A started access is never preempted.
//
// Optional feature (compile-time macro):
//   MEM_ARBITER_FLUSH_ABORT_EN
//     Defined:   if_flush during a fetch returns to IDLE at the next edge.
//     Undefined: the flushed fetch runs to completion on the RAM and only
//                its if_done pulse is suppressed.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   rdy              0 freezes all state and forces mem_wr low
//   if_req/if_addr   fetch request (always 4 bytes), held until if_done
//   if_flush         branch redirect, kills the in-flight fetch
//   if_done/if_inst  1-cycle completion pulse and fetched word
//   mem_req/mem_we/mem_len/mem_signed/mem_addr/mem_wdata
//                    load/store request, held until mem_done
//   mem_done/mem_rdata 1-cycle completion pulse and extended load data
//   mem_a/mem_dout/mem_wr  RAM address, write byte, write strobe
//   mem_din          RAM read byte, valid the cycle after its address
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [DATA_W-1:0] if_inst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic              mem_signed,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_dout,
    output logic              mem_wr,
    input  logic [7:0]        mem_din
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_IF_RD,
        S_MEM_RD,
        S_MEM_WR
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [2:0]        r_cnt;
    logic [2:0]        r_n;
    logic [ADDR_W-1:0] r_base;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_buf;
    logic [DATA_W-1:0] r_if_inst;
    logic [DATA_W-1:0] r_mem_rdata;
    logic              r_signed;
    logic              r_kill;
    logic              r_if_done;
    logic              r_mem_done;

    logic [2:0]        w_req_n;
    logic              w_grant_mem;
    logic              w_grant_if;
    logic              w_last_rd;
    logic              w_last_wr;
    logic              w_capture;
    logic [2:0]        w_off;
    logic [1:0]        w_bidx;
    logic [DATA_W-1:0] w_word;

    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] w,
                                                 input logic [2:0]        n,
                                                 input logic              s);
        case (n)
            3'd1:    extend = {{(DATA_W-8){s & w[7]}}, w[7:0]};
            3'd2:    extend = {{(DATA_W-16){s & w[15]}}, w[15:0]};
            default: extend = w;
        endcase
    endfunction

    always_comb begin
        case (mem_len)
            2'b00:   w_req_n = 3'd1;
            2'b01:   w_req_n = 3'd2;
            default: w_req_n = 3'd4;
        endcase
    end

    // A requester whose done is showing this cycle is still holding req;
    // masking it here prevents a duplicate grant.
    assign w_grant_mem = mem_req && !r_mem_done;
    assign w_grant_if  = !w_grant_mem && if_req && !r_if_done && !if_flush;
    assign w_last_rd   = (r_cnt == r_n);
    assign w_last_wr   = (r_cnt == (r_n - 3'd1));

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        if (rdy) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_grant_mem) begin
                        w_next = mem_we ? S_MEM_WR : S_MEM_RD;
                    end else if (w_grant_if) begin
                        w_next = S_IF_RD;
                    end
                end
                S_IF_RD: begin
`ifdef MEM_ARBITER_FLUSH_ABORT_EN
                    if (if_flush || w_last_rd) begin
                        w_next = S_IDLE;
                    end
`else
                    if (w_last_rd) begin
                        w_next = S_IDLE;
                    end
`endif
                end
                S_MEM_RD: begin
                    if (w_last_rd) begin
                        w_next = S_IDLE;
                    end
                end
                S_MEM_WR: begin
                    if (w_last_wr) begin
                        w_next = S_IDLE;
                    end
                end
            endcase
        end
    end

    // ---------------- RAM-side outputs ----------------
    always_comb begin
        mem_a     = '0;
        mem_dout  = '0;
        mem_wr    = 1'b0;
        w_capture = 1'b0;
        w_off     = '0;
        unique case (r_state)
            S_IF_RD, S_MEM_RD: begin
                // While frozen (and in the final capture cycle) keep the
                // address of the byte in flight on the bus, so mem_din still
                // holds that byte when the capture finally happens.
                if ((!rdy || w_last_rd) && (r_cnt != 3'd0)) begin
                    w_off = r_cnt - 3'd1;
                end else begin
                    w_off = r_cnt;
                end
                mem_a     = r_base + ADDR_W'(w_off);
                w_capture = rdy && (r_cnt != 3'd0);
            end
            S_MEM_WR: begin
                w_off    = r_cnt;
                mem_a    = r_base + ADDR_W'(w_off);
                mem_dout = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
                mem_wr   = rdy;
            end
            default: begin
            end
        endcase
    end

    // Word with the byte arriving this cycle merged in.
    always_comb begin
        w_bidx = 2'(r_cnt - 3'd1);
        w_word = r_buf;
        if (w_capture) begin
            w_word[{w_bidx, 3'b000} +: 8] = mem_din;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_n         <= '0;
            r_base      <= '0;
            r_wdata     <= '0;
            r_buf       <= '0;
            r_if_inst   <= '0;
            r_mem_rdata <= '0;
            r_signed    <= 1'b0;
            r_kill      <= 1'b0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
        end else if (rdy) begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;

            if ((r_state == S_IDLE) || (w_next == S_IDLE)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 3'd1;
            end

            if (w_capture) begin
                r_buf <= w_word;
            end

            if (r_state == S_IDLE) begin
                if (w_grant_mem) begin
                    r_base   <= mem_addr;
                    r_n      <= w_req_n;
                    r_signed <= mem_signed;
                    r_wdata  <= mem_wdata;
                end else if (w_grant_if) begin
                    r_base <= if_addr;
                    r_n    <= 3'd4;
                    r_kill <= 1'b0;
                end
            end

            if (r_state == S_IF_RD) begin
                if (if_flush) begin
                    r_kill <= 1'b1;
                end
                if (w_last_rd && !r_kill && !if_flush) begin
                    r_if_done <= 1'b1;
                    r_if_inst <= w_word;
                end
            end

            if ((r_state == S_MEM_RD) && w_last_rd) begin
                r_mem_done  <= 1'b1;
                r_mem_rdata <= extend(w_word, r_n, r_signed);
            end

            if ((r_state == S_MEM_WR) && w_last_wr) begin
                r_mem_done <= 1'b1;
            end
        end
    end

    assign if_done   = r_if_done;
    assign if_inst   = r_if_inst;
    assign mem_done  = r_mem_done;
    assign mem_rdata = r_mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter: byte RAM model, hand-written
//   multi-cycle sequences, a table of load/store vectors and randomized
//   traffic checked against a byte-array reference model.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_done;
    logic [31:0] if_inst;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_len;
    logic        mem_signed;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;

    int n_vec  = 0;
    int n_fail = 0;

    // 1 KiB RAM; addresses alias modulo 1024. Bench preload uses its own port.
    logic [7:0] ram    [1024];
    logic [7:0] shadow [1024];
    logic       pre_we;
    logic [9:0] pre_a;
    logic [7:0] pre_d;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_flush   (if_flush),
        .if_done    (if_done),
        .if_inst    (if_inst),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_len    (mem_len),
        .mem_signed (mem_signed),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_done   (mem_done),
        .mem_rdata  (mem_rdata),
        .mem_a      (mem_a),
        .mem_dout   (mem_dout),
        .mem_wr     (mem_wr),
        .mem_din    (mem_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_a] <= pre_d;
        end else if (mem_wr) begin
            ram[mem_a[9:0]] <= mem_dout;
        end
        mem_din <= ram[mem_a[9:0]];
    end

    typedef struct {
        bit          pre_en;
        logic [31:0] pre_a;
        logic [31:0] pre_w;
        bit          we;
        logic [1:0]  len;
        bit          sgn;
        logic [31:0] addr;
        logic [31:0] wd;
        int          fz_at;
        int          fz_len;
        logic [31:0] exp_d;
        int          exp_c;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] len);
        return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input int nb, input bit sgn);
        logic [31:0] v;
        logic [31:0] a;
        v = '0;
        for (int i = 0; i < nb; i++) begin
            a = addr + 32'(i);
            v = v | (32'(shadow[a[9:0]]) << (8 * i));
        end
        if (sgn && nb < 4 && (((v >> (8 * nb - 1)) & 32'd1) != 0)) begin
            v = v | (32'hFFFF_FFFF << (8 * nb));
        end
        return v;
    endfunction

    task automatic model_store(input logic [31:0] addr, input int nb, input logic [31:0] wd);
        logic [31:0] a;
        for (int i = 0; i < nb; i++) begin
            a = addr + 32'(i);
            shadow[a[9:0]] = 8'(wd >> (8 * i));
        end
    endtask

    task automatic preload_byte(input logic [31:0] addr, input logic [7:0] b);
        pre_we = 1'b1;
        pre_a  = addr[9:0];
        pre_d  = b;
        shadow[addr[9:0]] = b;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic preload_word(input logic [31:0] addr, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            preload_byte(addr + 32'(i), 8'(w >> (8 * i)));
        end
    endtask

    // Issue one request, optionally freeze rdy for fz_len cycles starting in
    // cycle fz_at, and report the cycle (counted from the grant edge) in which
    // done appeared, or -1 if it never did.
    task automatic run_access(input bit is_if, input bit we, input logic [1:0] len,
                              input bit sgn, input logic [31:0] addr, input logic [31:0] wd,
                              input int fz_at, input int fz_len,
                              output logic [31:0] data, output int cyc);
        cyc  = -1;
        data = '0;
        if (is_if) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            mem_req    = 1'b1;
            mem_we     = we;
            mem_len    = len;
            mem_signed = sgn;
            mem_addr   = addr;
            mem_wdata  = wd;
        end
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (is_if ? if_done : mem_done) begin
                cyc  = c;
                data = is_if ? if_inst : mem_rdata;
                break;
            end
            if (fz_len > 0 && c == fz_at) rdy = 1'b0;
            if (fz_len > 0 && c == fz_at + fz_len) rdy = 1'b1;
        end
        rdy     = 1'b1;
        if_req  = 1'b0;
        mem_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] d;
        int          cyc;
        int          md;
        int          id;
        int          seen;
        logic [7:0]  sb [4];

        rst = 1'b1; rdy = 1'b1;
        if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_len = '0; mem_signed = 1'b0;
        mem_addr = '0; mem_wdata = '0;
        pre_we = 1'b0; pre_a = '0; pre_d = '0;

        @(negedge clk);
        for (int i = 0; i < 1024; i++) begin
            preload_byte(32'(i), 8'($urandom_range(0, 255)));
        end

        // ---- reset state ----
        chk("rst_if_done",   {31'd0, if_done},  32'd0);
        chk("rst_if_inst",   if_inst,           32'd0);
        chk("rst_mem_done",  {31'd0, mem_done}, 32'd0);
        chk("rst_mem_rdata", mem_rdata,         32'd0);
        chk("rst_mem_a",     mem_a,             32'd0);
        chk("rst_mem_dout",  {24'd0, mem_dout}, 32'd0);
        chk("rst_mem_wr",    {31'd0, mem_wr},   32'd0);
        rst = 1'b0;
        @(negedge clk);

        // ---- word fetch, byte addresses, latency, no re-grant ----
        preload_word(32'h100, 32'h0000_0513);
        if_req = 1'b1; if_addr = 32'h100;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                chk($sformatf("fetch_addr%0d", c), mem_a, 32'h100 + 32'(c - 1));
                chk($sformatf("fetch_wr%0d", c), {31'd0, mem_wr}, 32'd0);
            end
            if (c < 6) chk($sformatf("fetch_early_done%0d", c), {31'd0, if_done}, 32'd0);
        end
        chk("fetch_done_c6", {31'd0, if_done}, 32'd1);
        chk("fetch_inst", if_inst, 32'h0000_0513);
        @(negedge clk);
        chk("fetch_no_regrant", mem_a, 32'd0);
        chk("fetch_done_pulse", {31'd0, if_done}, 32'd0);
        chk("fetch_inst_hold", if_inst, 32'h0000_0513);
        if_req = 1'b0;
        @(negedge clk);

        // ---- store word byte sequence ----
        sb[0] = 8'hEF; sb[1] = 8'hBE; sb[2] = 8'hAD; sb[3] = 8'hDE;
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_signed = 1'b0;
        mem_addr = 32'h40; mem_wdata = 32'hDEAD_BEEF;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                chk($sformatf("st_wr%0d", c), {31'd0, mem_wr}, 32'd1);
                chk($sformatf("st_a%0d", c), mem_a, 32'h40 + 32'(c - 1));
                chk($sformatf("st_dout%0d", c), {24'd0, mem_dout}, {24'd0, sb[c-1]});
                chk($sformatf("st_early_done%0d", c), {31'd0, mem_done}, 32'd0);
            end
        end
        chk("st_done_c5", {31'd0, mem_done}, 32'd1);
        chk("st_wr_off", {31'd0, mem_wr}, 32'd0);
        mem_req = 1'b0;
        model_store(32'h40, 4, 32'hDEAD_BEEF);
        @(negedge clk);

        // ---- contention: MEM first, fetch right after mem_done ----
        preload_word(32'h20, 32'h0000_0080);
        md = 0; id = 0;
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_signed = 1'b1; mem_addr = 32'h20;
        if_req = 1'b1; if_addr = 32'h100;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) chk("cont_mem_first", mem_a, 32'h20);
            if (md > 0 && c == md + 1) begin
                chk("cont_if_next", mem_a, 32'h100);
                mem_req = 1'b0;
            end
            if (mem_done && md == 0) begin
                md = c;
                chk("cont_rdata", mem_rdata, 32'hFFFF_FF80);
            end
            if (if_done) begin
                id = c;
                chk("cont_inst", if_inst, 32'h0000_0513);
                break;
            end
        end
        if_req = 1'b0; mem_req = 1'b0;
        chk("cont_mem_done_cyc", 32'(md), 32'd3);
        chk("cont_if_done_cyc", 32'(id), 32'd9);
        @(negedge clk);

        // ---- flush in cycle 3 of a fetch ----
        preload_word(32'h200, 32'hCAFE_0001);
        seen = 0;
        if_req = 1'b1; if_addr = 32'h200;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (if_done) seen++;
            if (c == 3) begin
                if_flush = 1'b1;
                if_req   = 1'b0;
            end
            if (c == 4) begin
`ifdef MEM_ARBITER_FLUSH_ABORT_EN
                chk("flush_abort_idle", mem_a, 32'd0);
`else
                chk("flush_runs_on", mem_a, 32'h203);
`endif
                if_flush = 1'b0;
            end
        end
        chk("flush_no_done", 32'(seen), 32'd0);

        // ---- flush in IDLE blocks the grant ----
        if_req = 1'b1; if_flush = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        chk("flush_blocks_grant", mem_a, 32'd0);
        if_flush = 1'b0;
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 0, 0, d, cyc);
        chk("post_flush_cyc", 32'(cyc), 32'd6);
        chk("post_flush_inst", d, 32'h0000_0513);

        // ---- mem_wr forced low while frozen ----
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b00; mem_addr = 32'h90; mem_wdata = 32'h5A;
        @(negedge clk);
        rdy = 1'b0;
        @(negedge clk);
        chk("freeze_wr_low", {31'd0, mem_wr}, 32'd0);
        rdy = 1'b1;
        #1;
        chk("resume_wr", {31'd0, mem_wr}, 32'd1);
        @(negedge clk);
        chk("freeze_st_done", {31'd0, mem_done}, 32'd1);
        mem_req = 1'b0;
        model_store(32'h90, 1, 32'h5A);
        @(negedge clk);

        // ---- reset in the middle of a store ----
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h80; mem_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_wr", {31'd0, mem_wr}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_drops_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_drops_a", mem_a, 32'd0);
        mem_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (mem_done || mem_wr || (mem_a != 32'd0)) seen++;
        end
        chk("rst_idle_after", 32'(seen), 32'd0);
        preload_word(32'h80, 32'h0BAD_0BAD);

        // ---- table-driven loads/stores ----
        tbl[0]  = '{1'b1, 32'h20,       32'h0000_0080, 1'b0, 2'b00, 1'b1, 32'h20,       32'h0,          0, 0, 32'hFFFF_FF80, 3};
        tbl[1]  = '{1'b0, 32'h0,        32'h0,         1'b0, 2'b00, 1'b0, 32'h20,       32'h0,          0, 0, 32'h0000_0080, 3};
        tbl[2]  = '{1'b1, 32'h30,       32'h0000_F234, 1'b0, 2'b01, 1'b1, 32'h30,       32'h0,          0, 0, 32'hFFFF_F234, 4};
        tbl[3]  = '{1'b0, 32'h0,        32'h0,         1'b0, 2'b01, 1'b0, 32'h30,       32'h0,          0, 0, 32'h0000_F234, 4};
        tbl[4]  = '{1'b1, 32'h50,       32'h1234_5678, 1'b0, 2'b10, 1'b0, 32'h50,       32'h0,          0, 0, 32'h1234_5678, 6};
        tbl[5]  = '{1'b0, 32'h0,        32'h0,         1'b0, 2'b11, 1'b1, 32'h50,       32'h0,          2, 3, 32'h1234_5678, 9};
        tbl[6]  = '{1'b0, 32'h0,        32'h0,         1'b0, 2'b00, 1'b1, 32'h50,       32'h0,          0, 0, 32'h0000_0078, 3};
        tbl[7]  = '{1'b0, 32'h0,        32'h0,         1'b0, 2'b10, 1'b0, 32'h40,       32'h0,          0, 0, 32'hDEAD_BEEF, 6};
        tbl[8]  = '{1'b1, 32'h60,       32'hFFFF_FF00, 1'b1, 2'b00, 1'b0, 32'h60,       32'h1234_56A5,  0, 0, 32'h0,         2};
        tbl[9]  = '{1'b0, 32'h0,        32'h0,         1'b0, 2'b10, 1'b0, 32'h60,       32'h0,          0, 0, 32'hFFFF_FFA5, 6};
        tbl[10] = '{1'b0, 32'h0,        32'h0,         1'b1, 2'b01, 1'b0, 32'h61,       32'h0000_BEEF,  0, 0, 32'h0,         3};
        tbl[11] = '{1'b0, 32'h0,        32'h0,         1'b0, 2'b10, 1'b0, 32'h60,       32'h0,          0, 0, 32'hFFBE_EFA5, 6};
        tbl[12] = '{1'b1, 32'hFFFF_FFFE, 32'h4433_2211, 1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0,        0, 0, 32'h4433_2211, 6};
        tbl[13] = '{1'b0, 32'h0,        32'h0,         1'b0, 2'b01, 1'b1, 32'hFFFF_FFFF, 32'h0,         0, 0, 32'h0000_3322, 4};
        tbl[14] = '{1'b0, 32'h0,        32'h0,         1'b1, 2'b10, 1'b0, 32'h70,       32'h0102_0304,  1, 2, 32'h0,         7};
        tbl[15] = '{1'b0, 32'h0,        32'h0,         1'b0, 2'b01, 1'b1, 32'h72,       32'h0,          0, 0, 32'h0000_0102, 4};
        tbl[16] = '{1'b0, 32'h0,        32'h0,         1'b0, 2'b00, 1'b0, 32'h20,       32'h0,          2, 2, 32'h0000_0080, 5};

        for (int v = 0; v < 17; v++) begin
            if (tbl[v].pre_en) preload_word(tbl[v].pre_a, tbl[v].pre_w);
            run_access(1'b0, tbl[v].we, tbl[v].len, tbl[v].sgn, tbl[v].addr, tbl[v].wd,
                       tbl[v].fz_at, tbl[v].fz_len, d, cyc);
            chk($sformatf("tbl%0d_cyc", v), 32'(cyc), 32'(tbl[v].exp_c));
            if (tbl[v].we) begin
                model_store(tbl[v].addr, nbytes(tbl[v].len), tbl[v].wd);
            end else begin
                chk($sformatf("tbl%0d_data", v), d, tbl[v].exp_d);
            end
        end

        // ---- randomized traffic against the byte-array model ----
        for (int r = 0; r < 150; r++) begin
            int          op;
            int          nb;
            int          fa;
            int          fl;
            int          exp_c;
            logic [1:0]  len;
            bit          sgn;
            logic [31:0] addr;
            logic [31:0] wd;
            op   = $urandom_range(0, 2);
            len  = (op == 0) ? 2'b10 : 2'($urandom_range(0, 3));
            sgn  = 1'($urandom_range(0, 1));
            addr = $urandom();
            wd   = $urandom();
            nb   = nbytes(len);
            fa   = 0;
            fl   = 0;
            if ($urandom_range(0, 2) == 0) begin
                fl = $urandom_range(1, 4);
                fa = $urandom_range(1, nb);
            end
            exp_c = ((op == 2) ? nb + 1 : nb + 2) + fl;
            run_access(op == 0, op == 2, len, sgn, addr, wd, fa, fl, d, cyc);
            chk($sformatf("rnd%0d_cyc", r), 32'(cyc), 32'(exp_c));
            if (op == 2) begin
                model_store(addr, nb, wd);
            end else begin
                chk($sformatf("rnd%0d_data", r), d, model_load(addr, nb, (op == 1) && sgn));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
